// File: rtl/shorten_positive_signals.sv
// Debounces a bouncy, active-high level into one-cycle press strobes plus held/busy status.
// Define SHORTEN_AUTO_REPEAT_EN to add auto-repeat strobes while the press stays held.
module shorten_positive_signals #(
    parameter int unsigned STABLE_CYCLES = 20,
    parameter int unsigned REPEAT_DELAY  = 100,
    parameter int unsigned REPEAT_PERIOD = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    output logic pulse,
    output logic held,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

    // Out-of-range parameters are rejected at elaboration rather than producing a silent misbehaviour.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 ||
        REPEAT_DELAY  < 2 || REPEAT_DELAY  > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_bad_params
        $error("shorten_positive_signals: parameter out of range 2..65535");
    end

    logic   sync1_q;
    logic   sync2_q;
    logic   sig_s;
    state_t state_q;
    state_t state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic   press_d;
    logic   rpt_fire_s;
    logic   pulse_q;
    logic   held_q;
    logic   busy_q;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= signal;
            sync2_q <= sync1_q;
        end
    end

    assign sig_s = sync2_q;

    // Next-state logic; cnt measures how long the synchronized level has stayed at its new value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sig_s) begin
                    state_d = QUALIFY;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                end
            end
            QUALIFY: begin
                if (!sig_s) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = 16'd0;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (!sig_s) begin
                    state_d = RELEASE;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                end
            end
            RELEASE: begin
                if (sig_s) begin
                    state_d = HELD;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef SHORTEN_AUTO_REPEAT_EN
    localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_q;
    logic [15:0] rpt_d;
    logic        rpt_per_q;
    logic        rpt_per_d;

    // Repeat timer: first target is the initial delay, later targets are the period; frozen in RELEASE.
    always_comb begin
        rpt_d      = rpt_q;
        rpt_per_d  = rpt_per_q;
        rpt_fire_s = 1'b0;
        if (state_q == HELD && state_d == HELD) begin
            if (rpt_q == (rpt_per_q ? PER_LAST : DLY_LAST)) begin
                rpt_fire_s = 1'b1;
                rpt_d      = 16'd0;
                rpt_per_d  = 1'b1;
            end else begin
                rpt_d      = rpt_q + 16'd1;
            end
        end else if (state_d == HELD) begin
            rpt_d     = 16'd0;
            rpt_per_d = 1'b0;
        end else if (state_d == RELEASE) begin
            rpt_d     = rpt_q;
            rpt_per_d = rpt_per_q;
        end else begin
            rpt_d     = 16'd0;
            rpt_per_d = 1'b0;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q     <= 16'd0;
            rpt_per_q <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_per_q <= rpt_per_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= press_d | rpt_fire_s;
            held_q  <= (state_d == HELD) || (state_d == RELEASE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;
    assign busy  = busy_q;

endmodule
